// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: ALU-control pipeline stage. Decodes opcode/funct into an
// ALU operation code, holds it in an ID/EX-style register under a
// valid/ready handshake, and sequences the multi-cycle MUL/DIV operations
// while back-pressuring upstream.
module alu_ctrl_stage #(
    parameter int OPC_W      = 5,
    parameter int FUNCT_W    = 5,
    parameter int OP_W       = 5,
    parameter int OPC_ART    = 0,
    parameter int OPC_LOG    = 1,
    parameter int OPC_CRY    = 2,
    parameter int OPC_IMM    = 3,
    parameter int OPC_LD     = 4,
    parameter int OPC_ST     = 5,
    parameter int OP_IMMED   = 16,
    parameter int FN_MUL     = 8,
    parameter int FN_DIV     = 9,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               stall_in,
    input  logic               flush,
    output logic               ready_out,
    output logic               valid_out,
    output logic [OP_W-1:0]    operation,
    output logic               op_start,
    output logic               busy,
    output logic               illegal
);

    // Counter only has to reach LAT-1 of the longest multi-cycle op.
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_operation;
    logic               r_illegal;
    logic               r_op_start;
    logic               r_busy;
    logic               r_valid_out;

    logic [OP_W-1:0]    w_dec_op;
    logic               w_dec_illegal;
    logic               w_dec_multi;
    logic [CNT_W-1:0]   w_dec_cnt;
    logic               w_ready;
    logic               w_accept;

    // Decode the incoming instruction: operation code, illegal flag and,
    // for MUL/DIV, the initial down-counter value (LAT-1).
    always_comb begin
        w_dec_op      = '0;
        w_dec_illegal = 1'b0;
        w_dec_multi   = 1'b0;
        w_dec_cnt     = '0;
        if (opcode == OPC_W'(OPC_ART) || opcode == OPC_W'(OPC_LOG) ||
            opcode == OPC_W'(OPC_CRY)) begin
            w_dec_op = OP_W'(funct);
        end else if (opcode == OPC_W'(OPC_IMM) || opcode == OPC_W'(OPC_LD) ||
                     opcode == OPC_W'(OPC_ST)) begin
            w_dec_op = OP_W'(OP_IMMED);
        end else begin
            w_dec_illegal = 1'b1;
        end
        if (opcode == OPC_W'(OPC_ART) && funct == FUNCT_W'(FN_MUL)) begin
            w_dec_multi = 1'b1;
            w_dec_cnt   = CNT_W'(MUL_CYCLES - 1);
        end else if (opcode == OPC_W'(OPC_ART) && funct == FUNCT_W'(FN_DIV)) begin
            w_dec_multi = 1'b1;
            w_dec_cnt   = CNT_W'(DIV_CYCLES - 1);
        end
    end

    // Ready is combinational on stall_in so a draining VALID slot can be
    // refilled in the same cycle (one instruction per cycle throughput).
    // Flush does not gate ready; upstream must honour flush itself.
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_VALID && !stall_in);
    assign w_accept = valid_in && w_ready;

    // Stage FSM with registered outputs; rst beats flush beats accept/advance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_operation <= '0;
            r_illegal   <= 1'b0;
            r_op_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            case (r_state)
                S_MULTI: begin
                    // stall_in is ignored while the multi-cycle op executes.
                    r_op_start <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state     <= S_VALID;
                        r_busy      <= 1'b0;
                        r_valid_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_IDLE, S_VALID: begin
                    if (w_accept) begin
                        r_operation <= w_dec_op;
                        r_illegal   <= w_dec_illegal;
                        if (w_dec_multi) begin
                            r_state     <= S_MULTI;
                            r_cnt       <= w_dec_cnt;
                            r_op_start  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_valid_out <= 1'b0;
                        end else begin
                            r_state     <= S_VALID;
                            r_cnt       <= '0;
                            r_op_start  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_valid_out <= 1'b1;
                        end
                    end else if (r_state == S_VALID && !stall_in) begin
                        // Consumed with nothing new behind it; operation
                        // and illegal keep their last accepted values.
                        r_state     <= S_IDLE;
                        r_valid_out <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_op_start  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = w_ready;
    assign valid_out = r_valid_out;
    assign operation = r_operation;
    assign op_start  = r_op_start;
    assign busy      = r_busy;
    assign illegal   = r_illegal;

endmodule
